// File: rtl/usart_pkg.sv
// Shared codes, FSM encoding and helpers for the USART receive path.
package usart_pkg;

    localparam logic [2:0] UCSZ_5 = 3'b000;
    localparam logic [2:0] UCSZ_6 = 3'b001;
    localparam logic [2:0] UCSZ_7 = 3'b010;
    localparam logic [2:0] UCSZ_8 = 3'b011;
    localparam logic [2:0] UCSZ_9 = 3'b111;

    localparam logic [1:0] UPM_OFF  = 2'b00;
    localparam logic [1:0] UPM_EVEN = 2'b10;
    localparam logic [1:0] UPM_ODD  = 2'b11;

    localparam logic [3:0] SMP_MID16  = 4'd9;
    localparam logic [3:0] SMP_MID8   = 4'd5;
    localparam logic [3:0] SMP_LAST16 = 4'd15;
    localparam logic [3:0] SMP_LAST8  = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic       fe;
        logic       upe;
        logic [8:0] data;
    } rx_entry_t;

    function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
        case (ucsz)
            UCSZ_5:  return 4'd5;
            UCSZ_6:  return 4'd6;
            UCSZ_7:  return 4'd7;
            UCSZ_8:  return 4'd8;
            UCSZ_9:  return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic parity_on(input logic [1:0] upm);
        case (upm)
            UPM_OFF:  return 1'b0;
            UPM_EVEN: return 1'b1;
            UPM_ODD:  return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usart_receiver_if.sv
// Receiver-side signal bundle: oversample tick, serial line, frame format and UDR/UCSRA view.
interface usart_receiver_if;
    logic       i_rxclk;
    logic       i_rxd;
    logic       i_RXEN;
    logic       i_UMSEL;
    logic       i_U2X;
    logic [2:0] i_UCSZ;
    logic [1:0] i_UPM;
    logic       i_re_udr;
    logic [7:0] o_udr;
    logic       o_RXB8;
    logic       o_RXC;
    logic       o_FE;
    logic       o_UPE;
    logic       o_DOR;

    modport master (
        output i_rxclk, i_rxd, i_RXEN, i_UMSEL, i_U2X, i_UCSZ, i_UPM, i_re_udr,
        input  o_udr, o_RXB8, o_RXC, o_FE, o_UPE, o_DOR
    );

    modport slave (
        input  i_rxclk, i_rxd, i_RXEN, i_UMSEL, i_U2X, i_UCSZ, i_UPM, i_re_udr,
        output o_udr, o_RXB8, o_RXC, o_FE, o_UPE, o_DOR
    );
endinterface

// File: rtl/usart_rx_fifo.sv
// Two-entry receive buffer; head is entry 0. Pop is applied before push, so a
// coincident pop frees the slot the push needs. Head reads as zero when empty.
module usart_rx_fifo
    import usart_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic      fosk_i,
    input  logic      rst_n_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  rx_entry_t din_i,
    input  logic      pop_i,
    output rx_entry_t head_o,
    output logic      empty_o,
    output logic      dor_o
);

    rx_entry_t  mem0_q, mem0_d, mem1_q, mem1_d;
    logic [1:0] cnt_q, cnt_d, cnt_pop;
    logic       dor_q, dor_d, pop_ok;

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        dor_d   = dor_q;
        pop_ok  = pop_i && (cnt_q != 2'd0);
        cnt_pop = cnt_q - {1'b0, pop_ok};
        cnt_d   = cnt_pop;
        if (pop_ok) begin
            mem0_d = mem1_q;
            dor_d  = 1'b0;
        end
        if (push_i) begin
            if (int'(cnt_pop) >= FIFO_DEPTH) begin
                dor_d = 1'b1;
            end else begin
                if (cnt_pop == 2'd0) mem0_d = din_i;
                else                 mem1_d = din_i;
                cnt_d = cnt_pop + 2'd1;
            end
        end
        if (flush_i) begin
            cnt_d = 2'd0;
            dor_d = 1'b0;
        end
    end

    always_ff @(posedge fosk_i) begin
        if (!rst_n_i) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
            dor_q  <= 1'b0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
            dor_q  <= dor_d;
        end
    end

    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = empty_o ? '0 : mem0_q;
    assign dor_o   = dor_q;

endmodule

// File: rtl/usart_receiver.sv
// USART receive stage: synchronizer, oversampled frame FSM and receive FIFO.
// States: IDLE wait low sample | START confirm start | DATA shift bits | PARITY check | STOP FE + push
module usart_receiver
    import usart_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic           i_fosk,
    input  logic           i_rst_n,
    usart_receiver_if.slave rx
);

    logic [1:0] sync_q;
    logic       rxd_s;

    always_ff @(posedge i_fosk) begin
        if (!i_rst_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], rx.i_rxd};
    end
    assign rxd_s = sync_q[1];

    rx_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d, idx_q, idx_d;
    logic [1:0] hist_q, hist_d;
    logic [8:0] data_q, data_d;
    logic       upe_q, upe_d;
    logic       push, fe;

    logic [3:0] smp_last, smp_vote, smp_cur, n_bits;
    logic       vote, is_vote, is_last;

    always_comb begin
        smp_last = rx.i_U2X ? SMP_LAST8 : SMP_LAST16;
        smp_vote = (rx.i_U2X ? SMP_MID8 : SMP_MID16) + 4'd1;
        smp_cur  = (cnt_q >= smp_last) ? 4'd0 : cnt_q + 4'd1;
        n_bits   = char_bits(rx.i_UCSZ);
        if (rx.i_UMSEL) begin
            vote    = rxd_s;
            is_vote = 1'b1;
            is_last = 1'b1;
        end else begin
            vote    = maj3(hist_q[1], hist_q[0], rxd_s);
            is_vote = (smp_cur == smp_vote);
            is_last = (smp_cur == smp_last);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hist_d  = hist_q;
        data_d  = data_q;
        upe_d   = upe_q;
        push    = 1'b0;
        fe      = 1'b0;
        if (!rx.i_RXEN) begin
            state_d = ST_IDLE;
        end else if (rx.i_rxclk) begin
            hist_d = {hist_q[0], rxd_s};
            cnt_d  = smp_cur;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 4'd0;
                    if (!rxd_s) begin
                        data_d  = '0;
                        upe_d   = 1'b0;
                        idx_d   = 4'd0;
                        // in sync mode the start bit is a single sample, already taken
                        state_d = rx.i_UMSEL ? ST_DATA : ST_START;
                    end
                end
                ST_START: begin
                    if (is_vote && vote) begin
                        state_d = ST_IDLE;
                    end else if (is_last) begin
                        state_d = ST_DATA;
                        idx_d   = 4'd0;
                    end
                end
                ST_DATA: begin
                    if (is_vote && (idx_q <= 4'd8)) data_d[idx_q] = vote;
                    if (is_last) begin
                        if (idx_q >= n_bits - 4'd1)
                            state_d = parity_on(rx.i_UPM) ? ST_PARITY : ST_STOP;
                        else
                            idx_d = idx_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (is_vote) upe_d = vote ^ (^data_q) ^ (rx.i_UPM == UPM_ODD);
                    if (is_last) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (is_vote) begin
                        fe      = ~vote;
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_fosk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            hist_q  <= 2'b11;
            data_q  <= '0;
            upe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            data_q  <= data_d;
            upe_q   <= upe_d;
        end
    end

    rx_entry_t push_entry, head;
    logic      fifo_empty, dor;

    assign push_entry = {fe, upe_q, data_q};

    usart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .fosk_i  (i_fosk),
        .rst_n_i (i_rst_n),
        .flush_i (!rx.i_RXEN),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (rx.i_re_udr),
        .head_o  (head),
        .empty_o (fifo_empty),
        .dor_o   (dor)
    );

    assign rx.o_RXC  = !fifo_empty;
    assign rx.o_udr  = head.data[7:0];
    assign rx.o_RXB8 = head.data[8];
    assign rx.o_FE   = head.fe;
    assign rx.o_UPE  = head.upe;
    assign rx.o_DOR  = dor;

endmodule

// File: tb/tb_usart_receiver.sv
// Bench for usart_receiver: frame-level model (expected entries + queue FIFO) checked every cycle.
module tb_usart_receiver;

    logic clk;
    logic rst_n;
    usart_receiver_if bus();

    usart_receiver #(.FIFO_DEPTH(2)) dut (
        .i_fosk  (clk),
        .i_rst_n (rst_n),
        .rx      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model: entries are {FE, UPE, data9}
    logic [10:0] mq[$];
    bit          mdor = 1'b0;

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got {RXC,DOR,FE,UPE,RXB8,udr}=%h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [12:0] dut_vec();
        return {bus.o_RXC, bus.o_DOR, bus.o_FE, bus.o_UPE, bus.o_RXB8, bus.o_udr};
    endfunction

    function automatic logic [12:0] model_vec();
        if (mq.size() != 0) return {1'b1, mdor, mq[0]};
        return {1'b0, mdor, 11'h000};
    endfunction

    function automatic int bits_of(input logic [2:0] ucsz);
        case (ucsz)
            3'b000:  return 5;
            3'b001:  return 6;
            3'b010:  return 7;
            3'b111:  return 9;
            default: return 8;
        endcase
    endfunction

    task automatic m_push(input logic [10:0] e);
        if (mq.size() < 2) mq.push_back(e);
        else               mdor = 1'b1;
    endtask

    task automatic m_pop();
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            mdor = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #3;
        if (chk_en) chk("cycle", dut_vec(), model_vec());
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one oversample tick every 4 clocks; line changes well before the tick
    task automatic sample(input logic v, input logic pop);
        bus.i_rxd = v;
        repeat (3) cyc();
        bus.i_rxclk  = 1'b1;
        bus.i_re_udr = pop;
        cyc();
        bus.i_rxclk  = 1'b0;
        bus.i_re_udr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) sample(1'b1, 1'b0);
    endtask

    task automatic rd();
        bus.i_re_udr = 1'b1;
        cyc();
        bus.i_re_udr = 1'b0;
        m_pop();
    endtask

    task automatic send_frame(input logic [8:0] d, input bit corrupt, input bit stop, input bit pop_at_push);
        int nb, osr, dec;
        bit pon, par, upe;
        logic [8:0] m;
        bit bits[$];
        nb  = bits_of(bus.i_UCSZ);
        pon = bus.i_UPM[1];
        osr = bus.i_UMSEL ? 1 : (bus.i_U2X ? 8 : 16);
        dec = bus.i_UMSEL ? 0 : (bus.i_U2X ? 6 : 10);
        m = '0;
        for (int i = 0; i < nb; i++) m[i] = d[i];
        par = (^m) ^ bus.i_UPM[0] ^ corrupt;
        upe = pon && (par != ((^m) ^ bus.i_UPM[0]));
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(m[i]);
        if (pon) bits.push_back(par);
        foreach (bits[k]) repeat (osr) sample(bits[k], 1'b0);
        for (int s = 0; s < osr; s++) begin
            if (s == dec) begin
                sample(stop, pop_at_push);
                if (pop_at_push) m_pop();
                m_push({~stop, upe, m});
            end else begin
                sample(stop, 1'b0);
            end
        end
    endtask

    task automatic set_fmt(input bit umsel, input bit u2x, input logic [2:0] ucsz, input logic [1:0] upm);
        bus.i_UMSEL = umsel;
        bus.i_U2X   = u2x;
        bus.i_UCSZ  = ucsz;
        bus.i_UPM   = upm;
    endtask

    initial begin
        bus.i_rxclk  = 1'b0;
        bus.i_rxd    = 1'b1;
        bus.i_RXEN   = 1'b1;
        bus.i_re_udr = 1'b0;
        set_fmt(1'b0, 1'b0, 3'b011, 2'b00);
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("reset", dut_vec(), 13'h0000);
        rst_n = 1'b1;
        cyc();
        chk_en = 1'b1;

        // 16x 8N1 0xA5
        idle(4);
        send_frame(9'h0A5, 1'b0, 1'b1, 1'b0);
        chk("a5_frame", dut_vec(), 13'h10A5);
        rd();
        chk("a5_read", dut_vec(), 13'h0000);

        // 8x, 9 bits, even parity, corrupted parity bit
        set_fmt(1'b0, 1'b1, 3'b111, 2'b10);
        idle(4);
        send_frame(9'h1C3, 1'b1, 1'b1, 1'b0);
        chk("p9_frame", dut_vec(), 13'h13C3);
        rd();

        // framing error, then a short glitch on idle
        set_fmt(1'b0, 1'b0, 3'b011, 2'b00);
        idle(4);
        send_frame(9'h055, 1'b0, 1'b0, 1'b0);
        idle(16);
        chk("fe_frame", dut_vec(), 13'h1455);
        rd();
        sample(1'b0, 1'b0);
        sample(1'b0, 1'b0);
        idle(20);
        chk("glitch", dut_vec(), 13'h0000);

        // overrun
        send_frame(9'h011, 1'b0, 1'b1, 1'b0);
        send_frame(9'h022, 1'b0, 1'b1, 1'b0);
        send_frame(9'h033, 1'b0, 1'b1, 1'b0);
        chk("ovr_head", dut_vec(), 13'h1811);
        rd();
        chk("ovr_rd1", dut_vec(), 13'h1022);
        rd();
        chk("ovr_rd2", dut_vec(), 13'h0000);

        // pop coincident with push while full
        send_frame(9'h010, 1'b0, 1'b1, 1'b0);
        send_frame(9'h020, 1'b0, 1'b1, 1'b0);
        send_frame(9'h044, 1'b0, 1'b1, 1'b1);
        chk("pp_head", dut_vec(), 13'h1020);
        rd();
        chk("pp_next", dut_vec(), 13'h1044);
        rd();

        // sync mode 7O1, then RXEN drop mid-frame
        set_fmt(1'b1, 1'b0, 3'b010, 2'b11);
        idle(3);
        send_frame(9'h03A, 1'b0, 1'b1, 1'b0);
        chk("sync_3a", dut_vec(), 13'h103A);
        sample(1'b0, 1'b0);
        sample(1'b1, 1'b0);
        sample(1'b0, 1'b0);
        bus.i_RXEN = 1'b0;
        cyc();
        mq.delete();
        mdor = 1'b0;
        chk("rxen_off", dut_vec(), 13'h0000);
        sample(1'b0, 1'b0);
        sample(1'b1, 1'b0);
        idle(2);
        bus.i_RXEN = 1'b1;
        idle(2);
        send_frame(9'h015, 1'b0, 1'b1, 1'b0);
        chk("rxen_again", dut_vec(), 13'h1015);
        rd();

        // randomized frames, formats and reads
        for (int it = 0; it < 40; it++) begin
            bit corrupt, stop, pap;
            logic [8:0] d;
            set_fmt(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            d       = 9'($urandom_range(0, 511));
            corrupt = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 4) != 0);
            pap     = ($urandom_range(0, 3) == 0);
            idle($urandom_range(0, 3));
            send_frame(d, corrupt, stop, pap);
            if (!stop) idle(16);
            repeat ($urandom_range(0, 2)) rd();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/usart_receiver.md
Name: usart_receiver

Overview:
- USART receive stage, directly downstream of clock_generator.
- Consumes the o_rxclk enable pulse: 16x/8x oversample tick in async mode, one tick per active XCK edge in sync mode.
- Recovers frames from RxD: start bit, 5–9 data bits LSB-first, optional parity, first stop bit only.
- Delivers received characters plus status flags through a 2-entry receive FIFO that the register interface reads as UDR/UCSRA.

Parameters:
- FIFO_DEPTH, 2, receive buffer entries; fixed at 2 for this revision, other values unsupported.

Ports:
- i_fosk  in  1  system clock; the only clock.
- i_rst_n  in  1  synchronous, active-low reset, sampled on posedge i_fosk.
- i_rxclk  in  1  receive enable pulse from clock_generator o_rxclk; one i_fosk cycle wide.
- i_rxd  in  1  serial input; asynchronous to i_fosk.
- i_RXEN  in  1  UCSRB RXEN, receiver enable.
- i_UMSEL  in  1  1 = synchronous mode, 0 = asynchronous mode.
- i_U2X  in  1  1 = 8x oversampling, 0 = 16x; ignored when i_UMSEL=1.
- i_UCSZ  in  3  character size: 000=5, 001=6, 010=7, 011=8, 111=9 bits; other codes treated as 8.
- i_UPM  in  2  parity: 00 = off, 10 = even, 11 = odd, 01 = off.
- i_re_udr  in  1  UDR read strobe; pops the FIFO head.
- o_udr  out  8  head entry data[7:0].
- o_RXB8  out  1  head entry data bit 8.
- o_RXC  out  1  FIFO not empty.
- o_FE  out  1  head entry frame error.
- o_UPE  out  1  head entry parity error.
- o_DOR  out  1  data overrun, sticky.

Behaviour:
- Reset (i_rst_n=0 at posedge): FSM to IDLE, FIFO empty, all outputs 0, synchronizer flops loaded with 1 (idle line).
- i_rxd passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- All sampling actions occur only on cycles with i_rxclk=1.
- Async mode:
  - Sample counter is 4 bits; wraps at 15 (16x) or 7 (8x).
  - Majority vote taken on samples 8,9,10 (16x) or 4,5,6 (8x).
  - Bit value is the majority of those three samples.
- Sync mode: each i_rxclk pulse is one bit sample; no majority vote.
- FSM states:
  - IDLE: on a low sample go to START and clear the sample counter.
  - START: if the start-bit vote gives 1 (false start), return to IDLE; otherwise, at the last sample of the bit, go to DATA with bit index = 0.
  - DATA: shift the vote result into bit[index]. After bit UCSZ-1 completes, go to PARITY if parity is enabled, else STOP.
  - PARITY: compute the expected parity (even: XOR of data = received bit; odd: inverted) and record UPE.
  - STOP: at the vote sample, FE = ~vote. Push {data9, FE, UPE} and go to IDLE immediately, so the next start can be detected within half a bit.
- Unused high data bits are written as 0. The 9-bit bit 8 is valid only when UCSZ=111.
- Push latency: o_RXC rises 1 i_fosk cycle after the i_rxclk pulse that carries the stop-bit decision.
- FIFO is 2 entries, head visible on outputs.
  - i_re_udr with FIFO empty: no effect.
  - i_re_udr pops the head and clears DOR.
  - Push and pop in the same cycle: pop first, then push; no overrun even when full.
  - Push while full with no pop: frame discarded, o_DOR set to 1.
- i_RXEN=0: FSM held in IDLE, FIFO flushed, o_DOR cleared, within 1 cycle; takes effect mid-frame too.
- Mode or format inputs changed mid-frame: undefined frame contents, no lockup. The FSM returns to IDLE by the end of the frame.
- Requirement on upstream: UBRR ≥ 1 so that i_rxclk is a pulse train.

Decomposition:
- usart_pkg holds:
  - UCSZ codes: UCSZ_5, UCSZ_6, UCSZ_7, UCSZ_8, UCSZ_9.
  - UPM codes: UPM_OFF, UPM_EVEN, UPM_ODD.
  - FSM state encodings: ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - Sample constants: SMP_MID16=9, SMP_MID8=5, SMP_LAST16=15, SMP_LAST8=7.
- One sub-module, usart_rx_fifo: 2-deep, 11-bit entries {FE, UPE, data9}; push, pop, full, empty, overrun.

Test Plan:
- 16x, 8N1, i_rxclk every 4 cycles, byte 0xA5 → o_udr=0xA5, o_RXC=1, FE=UPE=DOR=0; i_re_udr → o_RXC=0.
- 8x, 9 data bits, even parity, word 0x1C3 with a corrupted parity bit → o_RXB8=1, o_udr=0xC3, o_UPE=1, o_FE=0.
- Stop bit driven low, byte 0x55 → o_FE=1. A 2-sample low glitch on idle RxD (samples 0–1 only) → no frame, o_RXC stays 0.
- Three back-to-back frames 0x11, 0x22, 0x33 with no reads → o_udr=0x11, o_DOR=1. Two reads yield 0x11 then 0x22; DOR clears after the first read; 0x33 is lost.
- FIFO full, pop coincident with push of 0x44 → no DOR; order preserved (second entry, then 0x44).
- Sync mode, one i_rxclk per bit, 7O1, byte 0x3A → o_udr=0x3A, UPE=0. Drop i_RXEN mid-frame → FIFO empty; a subsequent frame is received cleanly.
